rot_checker: RTL and testbench

Receive-side checker for the 4-bit one-hot rotating pattern driven by the LED rotator test designs (`rot[3:0]`, left rotate by one position every clock). It synchronises the four pattern lines and tracks the expected sequence. It asserts lock after a programmable run of correct rotations and counts loss-of-lock errors. It sits on the opposite board or fabric region from the rotator and is used as a hardware self-check for place-and-route and timing tests.

---
 rtl/rot_pkg.sv | 39 +++
 rtl/rot_sync.sv | 34 +++
 rtl/rot_checker.sv | 143 ++++++++++++++
 tb/tb_rot_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// rot_pkg
//   Shared definitions for the rotating one-hot pattern: pattern width,
//   checker state encoding and the pattern helper functions. The rotator
//   test designs use rotl1 from here, so the transmitter and the checker
//   always agree on the direction of rotation.
package rot_pkg;

   localparam int ROT_W = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } rot_state_t;

   // Left rotate by one position: bit 3 wraps into bit 0.
   function automatic logic [ROT_W-1:0] rotl1(input logic [ROT_W-1:0] v);
      return {v[ROT_W-2:0], v[ROT_W-1]};
   endfunction

   // True when exactly one bit is set. All-zero and multi-bit are invalid.
   function automatic logic onehot_valid(input logic [ROT_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Index of the set bit. Returns 0 for an all-zero input; callers only
   // use the result for values that have already passed onehot_valid.
   function automatic logic [1:0] onehot_enc(input logic [ROT_W-1:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < ROT_W; i++) begin
         if (v[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rot_sync.sv
// rot_sync
//   Two-flop synchroniser for the pattern lines, which arrive asynchronous
//   to clk. Each bit is synchronised independently; the checker tolerates
//   a skewed transition because a torn sample is simply a mismatch.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears both stages to 0
//   d      in   W raw pattern lines
//   q      out  W synchronised lines (2 clk edges of latency)
module rot_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_reg;
   logic [W-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/rot_checker.sv
// rot_checker
//   Receive-side checker for a left-rotating 4-bit one-hot pattern.
//   Synchronises the lines, follows the expected sequence, declares lock
//   after LOCK_COUNT consecutive correct rotations and counts every loss
//   of lock in a saturating counter.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rot_in     in   4 pattern lines, bit 0 = transmitter D1, async to clk
//   locked     out  1 while the checker is in the LOCKED state
//   err        out  sticky: set on the first loss of lock
//   err_count  out  saturating count of loss-of-lock events
//   pos        out  index of the set bit of the last accepted sample,
//                   0 while searching
module rot_checker
   import rot_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ROT_W-1:0] rot_in,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       pos
);

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   logic [ROT_W-1:0] samp;
   logic [ROT_W-1:0] prev_reg;
   logic [ROT_W-1:0] exp_val;
   logic [3:0]       run_reg;
   logic [3:0]       run_inc;
   logic             samp_valid;
   logic             samp_match;
   logic [1:0]       samp_idx;
   logic             cnt_sat;

   rot_state_t       state_reg;
   logic             locked_reg;
   logic             err_reg;
   logic [ERR_W-1:0] err_count_reg;
   logic [1:0]       pos_reg;

   rot_sync #(.W(ROT_W)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rot_in),
      .q     (samp)
   );

   // prev is always one-hot, so a match with exp implies a valid sample.
   assign exp_val    = rotl1(prev_reg);
   assign samp_valid = onehot_valid(samp);
   assign samp_match = (samp == exp_val);
   assign samp_idx   = onehot_enc(samp);
   assign run_inc    = run_reg + 4'd1;
   assign cnt_sat    = &err_count_reg;

   // Outputs are registered alongside the state so locked and pos change
   // on the same edge as the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= SEARCH;
         prev_reg      <= 4'b0001;
         run_reg       <= 4'd0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
         err_count_reg <= '0;
         pos_reg       <= 2'd0;
      end else begin
         unique case (state_reg)
            SEARCH: begin
               if (samp_valid) begin
                  state_reg <= TRACK;
                  prev_reg  <= samp;
                  run_reg   <= 4'd0;
                  pos_reg   <= samp_idx;
               end
            end

            TRACK: begin
               if (samp_match) begin
                  prev_reg <= samp;
                  run_reg  <= run_inc;
                  pos_reg  <= samp_idx;
                  if (run_inc == LOCK_CNT) begin
                     state_reg  <= LOCKED;
                     locked_reg <= 1'b1;
                  end
               end else if (samp_valid) begin
                  // Out-of-sequence but clean: restart the run from here.
                  prev_reg <= samp;
                  run_reg  <= 4'd0;
                  pos_reg  <= samp_idx;
               end else begin
                  state_reg <= SEARCH;
                  pos_reg   <= 2'd0;
               end
            end

            LOCKED: begin
               if (samp_match) begin
                  prev_reg <= samp;
                  pos_reg  <= samp_idx;
               end else begin
                  // Loss of lock is counted once here; TRACK and SEARCH
                  // never count, so repeat faults add nothing until relock.
                  locked_reg <= 1'b0;
                  err_reg    <= 1'b1;
                  if (!cnt_sat) begin
                     err_count_reg <= err_count_reg + 1'b1;
                  end
                  if (samp_valid) begin
                     state_reg <= TRACK;
                     prev_reg  <= samp;
                     run_reg   <= 4'd0;
                     pos_reg   <= samp_idx;
                  end else begin
                     state_reg <= SEARCH;
                     pos_reg   <= 2'd0;
                  end
               end
            end

            default: begin
               state_reg  <= SEARCH;
               locked_reg <= 1'b0;
               pos_reg    <= 2'd0;
            end
         endcase
      end
   end

   assign locked    = locked_reg;
   assign err       = err_reg;
   assign err_count = err_count_reg;
   assign pos       = pos_reg;

endmodule

// File: tb/tb_rot_checker.sv
// tb_rot_checker
//   Directed bench for rot_checker. Two instances share clock, reset and
//   pattern lines: dut uses the default 8-bit error counter, dut_sat a
//   2-bit counter so saturation is reached within a few lock/unlock cycles.
module tb_rot_checker;
   import rot_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] rot_in;
   logic [3:0] pat;

   logic       locked,     locked_s;
   logic       err,        err_s;
   logic [7:0] err_count;
   logic [1:0] err_count_s;
   logic [1:0] pos,        pos_s;

   int n_checks = 0;
   int n_fail   = 0;

   rot_checker #(.LOCK_COUNT(4), .ERR_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rot_in    (rot_in),
      .locked    (locked),
      .err       (err),
      .err_count (err_count),
      .pos       (pos)
   );

   rot_checker #(.LOCK_COUNT(4), .ERR_W(2)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .rot_in    (rot_in),
      .locked    (locked_s),
      .err       (err_s),
      .err_count (err_count_s),
      .pos       (pos_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive a value ahead of the next rising edge, then settle 1 time unit past it.
   task automatic tick(input logic [3:0] v);
      rot_in = v;
      @(posedge clk);
      #1;
      $display("t=%0t rot_in=%b locked=%0d err=%0d err_count=%0d pos=%0d sat_count=%0d",
               $time, v, locked, err, err_count, pos, err_count_s);
   endtask

   // Drive the current pattern value and advance it by one left rotation.
   task automatic tick_rot();
      logic [3:0] v;
      v   = pat;
      pat = {pat[2:0], pat[3]};
      tick(v);
   endtask

   initial begin
      rst_n  = 1'b0;
      rot_in = 4'b0000;
      pat    = 4'b0001;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_locked", locked, 1'b0);
      chk("reset_err", err, 1'b0);
      chk("reset_count", err_count, 8'd0);
      chk("reset_pos", pos, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Startup zeros: SEARCH holds, nothing recorded.
      repeat (5) tick(4'b0000);
      chk("zeros_locked", locked, 1'b0);
      chk("zeros_err", err, 1'b0);
      chk("zeros_pos", pos, 2'd0);

      // Clean lock: first 0001 driven before edge 1, captured at edge 3.
      tick_rot();                                   // e1 0001
      tick_rot();                                   // e2 0010
      chk("clean_e2_pos", pos, 2'd0);
      tick_rot();                                   // e3 0100 (FSM takes 0001)
      chk("clean_e3_pos", pos, 2'd0);
      tick_rot();                                   // e4
      chk("clean_e4_pos", pos, 2'd1);
      tick_rot();                                   // e5
      chk("clean_e5_pos", pos, 2'd2);
      tick_rot();                                   // e6
      chk("clean_e6_pos", pos, 2'd3);
      chk("clean_e6_unlocked", locked, 1'b0);
      tick_rot();                                   // e7
      chk("clean_e7_locked", locked, 1'b1);
      chk("clean_e7_err", err, 1'b0);
      chk("clean_e7_pos", pos, 2'd0);

      // Dropped step: continue 1000, 0001, 0010, then skip 0100.
      tick_rot();                                   // e8 1000
      tick_rot();                                   // e9 0001
      tick_rot();                                   // e10 0010
      chk("drop_pre_locked", locked, 1'b1);
      pat = 4'b1000;
      tick_rot();                                   // e11 1000 (bad)
      tick_rot();                                   // e12 0001
      chk("drop_e12_locked", locked, 1'b1);
      tick_rot();                                   // e13 0010
      chk("drop_e13_unlocked", locked, 1'b0);
      chk("drop_err", err, 1'b1);
      chk("drop_count", err_count, 8'd1);
      chk("drop_pos_track", pos, 2'd3);
      tick_rot();                                   // e14
      tick_rot();                                   // e15
      tick_rot();                                   // e16
      chk("drop_e16_unlocked", locked, 1'b0);
      tick_rot();                                   // e17
      chk("drop_relock", locked, 1'b1);
      chk("drop_count_hold", err_count, 8'd1);

      // Stuck line: 0011 while locked (second loss of lock overall).
      tick(4'b0011);
      tick(4'b0011);
      chk("stuck_k1_locked", locked, 1'b1);
      tick(4'b0011);
      chk("stuck_unlocked", locked, 1'b0);
      chk("stuck_count", err_count, 8'd2);
      chk("stuck_pos_search", pos, 2'd0);
      repeat (5) tick(4'b0011);
      chk("stuck_count_hold", err_count, 8'd2);
      chk("stuck_locked_hold", locked, 1'b0);
      chk("stuck_sat_count", err_count_s, 2'd2);

      // Saturation: four more lock/unlock cycles.
      for (int c = 0; c < 4; c++) begin
         pat = 4'b0001;
         repeat (7) tick_rot();
         chk("sat_relock", locked, 1'b1);
         repeat (3) tick(4'b0000);
         chk("sat_unlock", locked, 1'b0);
      end
      chk("sat_main_count", err_count, 8'd6);
      chk("sat_count_held", err_count_s, 2'd3);
      chk("sat_err", err_s, 1'b1);

      // Async reset mid-lock.
      pat = 4'b0001;
      repeat (7) tick_rot();
      chk("arst_pre_locked", locked, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 1'b0);
      chk("arst_err", err, 1'b0);
      chk("arst_count", err_count, 8'd0);
      chk("arst_pos", pos, 2'd0);
      chk("arst_sat_count", err_count_s, 2'd0);
      #1;
      rst_n = 1'b1;
      repeat (6) tick_rot();
      chk("arst_e6_unlocked", locked, 1'b0);
      tick_rot();
      chk("arst_relock", locked, 1'b1);
      chk("arst_err_after", err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
